// File: rtl/upower_pkg.sv
// Shared types and widths for the uPOWER instruction fetch front-end.
package upower_pkg;

    localparam int INST_W = 32;
    localparam int PC_W   = 32;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [PC_W-1:0]   pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_buffer.sv
// Two-entry FIFO of {inst, pc} pairs; entry0 is always the head.
import upower_pkg::*;

module fetch_skid_buffer (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    fetch_entry_t entry0;
    fetch_entry_t entry1;

    assign head = entry0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            entry0 <= '0;
            entry1 <= '0;
            count  <= 2'd0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) entry0 <= din;
                    else               entry1 <= din;
                    if (count != 2'd2) count <= count + 2'd1;
                end
                2'b01: begin
                    if (count != 2'd0) begin
                        entry0 <= entry1;
                        count  <= count - 2'd1;
                    end
                end
                2'b11: begin
                    // A pop on an empty buffer is meaningless, so treat it as a plain push
                    if (count == 2'd0) begin
                        entry0 <= din;
                        count  <= 2'd1;
                    end else if (count == 2'd1) begin
                        entry0 <= din;
                    end else begin
                        entry0 <= entry1;
                        entry1 <= din;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/upower_fetch_unit.sv
// Fetch front-end: PC, instruction-memory requests, skid buffering toward decode.
// RUN: fetching | DRAIN: halt pending, delivering buffered words | HALTED: idle until redirect
import upower_pkg::*;

module upower_fetch_unit #(
    parameter int          IMEM_AW  = 6,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clock,
    input  logic               reset_n,
    output logic               imem_en,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    input  logic               halt_req,
    output logic               inst_valid,
    input  logic               inst_ready,
    output logic [31:0]        inst,
    output logic [31:0]        inst_pc,
    output logic               halted
);

    fetch_state_t      state;
    fetch_state_t      state_next;
    logic [PC_W-1:0]   pc;
    logic [PC_W-1:0]   rsp_pc;
    logic              inflight;
    logic              rsp_live;
    logic              buf_empty;
    logic              buf_push;
    logic              buf_pop;
    logic              accept;
    logic              issue;
    logic [2:0]        level;
    logic [1:0]        buf_count;
    fetch_entry_t      buf_head;
    fetch_entry_t      rsp_entry;

    // A response returning in a redirect cycle belongs to the old path and is dropped
    assign rsp_live  = inflight && !redirect_valid;
    assign buf_empty = (buf_count == 2'd0);
    assign rsp_entry = '{inst: imem_rdata, pc: rsp_pc};

    assign inst_valid = !redirect_valid && (!buf_empty || inflight);
    assign inst       = (buf_empty && inflight) ? imem_rdata : buf_head.inst;
    assign inst_pc    = (buf_empty && inflight) ? rsp_pc     : buf_head.pc;

    assign accept   = inst_valid && inst_ready;
    assign buf_pop  = accept && !buf_empty;
    assign buf_push = rsp_live && !(accept && buf_empty);

    // Words held after this edge plus the one returning; a new fetch must fit in two slots
    assign level = {1'b0, buf_count} + {2'b00, inflight} - {2'b00, buf_pop};
    assign issue = reset_n && (state == RUN) && !halt_req && !redirect_valid && (level < 3'd2);

    assign imem_en   = issue;
    assign imem_addr = pc[IMEM_AW+1:2];
    assign halted    = (state == HALTED);

    fetch_skid_buffer u_skid (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (buf_push),
        .pop     (buf_pop),
        .flush   (redirect_valid),
        .din     (rsp_entry),
        .head    (buf_head),
        .count   (buf_count)
    );

    always_comb begin
        state_next = state;
        if (redirect_valid) begin
            state_next = halt_req ? DRAIN : RUN;
        end else begin
            case (state)
                RUN:     if (halt_req) state_next = DRAIN;
                DRAIN: begin
                    if (!halt_req)                   state_next = RUN;
                    else if (!inflight && buf_empty) state_next = HALTED;
                end
                HALTED:  state_next = HALTED;
                default: state_next = RUN;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= RUN;
            pc       <= RESET_PC;
            inflight <= 1'b0;
            rsp_pc   <= '0;
        end else begin
            state    <= state_next;
            inflight <= issue;
            if (issue) rsp_pc <= pc;
            if (redirect_valid) pc <= redirect_pc & 32'hFFFF_FFFC;
            else if (issue)     pc <= pc + 32'd4;
        end
    end

endmodule

// File: tb/tb_upower_fetch_unit.sv
// Self-checking bench for upower_fetch_unit: directed vector table, corner sequences, random scoreboard.
module tb_upower_fetch_unit;

    logic        clock;
    logic        reset_n;
    logic        imem_en;
    logic [5:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt_req;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        halted;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem [64];

    typedef struct {
        logic        ready;
        logic        halt;
        logic        redir;
        logic [31:0] rpc;
        logic        exp_en;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic        exp_halted;
    } vec_t;

    vec_t vq[$];

    upower_fetch_unit dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .imem_en        (imem_en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .halted         (halted)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous instruction memory: data appears the cycle after the read strobe
    always @(posedge clock) begin
        if (imem_en) imem_rdata <= mem[imem_addr];
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] word_at(input logic [31:0] pc);
        return 32'h3820_0001 + ((pc >> 2) % 64);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input logic ready, input logic halt, input logic redir, input logic [31:0] rpc);
        inst_ready     = ready;
        halt_req       = halt;
        redirect_valid = redir;
        redirect_pc    = rpc;
        #1;
    endtask

    logic [31:0] exp_pc;
    logic [31:0] hold_pc;
    logic [31:0] hold_inst;
    logic [31:0] r_pc;
    logic        prev_hold;
    logic        prev_redir;
    logic        r_redir;
    logic        r_halt;
    int          n_tx;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h3820_0001 + i;
        imem_rdata = 32'hDEAD_BEEF;
        reset_n = 1'b0;
        apply(1'b0, 1'b0, 1'b0, 32'h0);

        //            ready halt redir rpc            en valid pc           halted
        vq.push_back('{1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 32'h00, 1'b0});
        vq.push_back('{1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h00, 1'b0});
        vq.push_back('{1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h04, 1'b0});
        vq.push_back('{1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h08, 1'b0});
        vq.push_back('{1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 32'h08, 1'b0});
        vq.push_back('{1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 32'h08, 1'b0});
        vq.push_back('{1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 32'h08, 1'b0});
        vq.push_back('{1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 32'h08, 1'b0});
        vq.push_back('{1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h08, 1'b0});
        vq.push_back('{1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h0C, 1'b0});
        vq.push_back('{1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h10, 1'b0});
        vq.push_back('{1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h14, 1'b0});
        vq.push_back('{1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 32'h18, 1'b0});
        vq.push_back('{1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 32'h18, 1'b0});
        vq.push_back('{1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 32'h1C, 1'b0});
        vq.push_back('{1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 32'h00, 1'b0});
        vq.push_back('{1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 32'h00, 1'b1});
        vq.push_back('{1'b1, 1'b0, 1'b1, 32'h10, 1'b0, 1'b0, 32'h00, 1'b1});
        vq.push_back('{1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 32'h00, 1'b0});
        vq.push_back('{1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h10, 1'b0});
        vq.push_back('{1'b0, 1'b0, 1'b1, 32'h43, 1'b0, 1'b0, 32'h00, 1'b0});
        vq.push_back('{1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 32'h00, 1'b0});
        vq.push_back('{1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h40, 1'b0});

        repeat (3) @(negedge clock);
        #1;
        check("reset_imem_en",    {31'd0, imem_en},    32'd0);
        check("reset_imem_addr",  {26'd0, imem_addr},  32'd0);
        check("reset_inst_valid", {31'd0, inst_valid}, 32'd0);
        check("reset_inst",       inst,                32'd0);
        check("reset_inst_pc",    inst_pc,             32'd0);
        check("reset_halted",     {31'd0, halted},     32'd0);

        @(negedge clock);
        reset_n = 1'b1;
        foreach (vq[i]) begin
            apply(vq[i].ready, vq[i].halt, vq[i].redir, vq[i].rpc);
            check($sformatf("row%0d_imem_en", i),    {31'd0, imem_en},    {31'd0, vq[i].exp_en});
            check($sformatf("row%0d_inst_valid", i), {31'd0, inst_valid}, {31'd0, vq[i].exp_valid});
            check($sformatf("row%0d_halted", i),     {31'd0, halted},     {31'd0, vq[i].exp_halted});
            if (vq[i].exp_valid) begin
                check($sformatf("row%0d_inst_pc", i), inst_pc, vq[i].exp_pc);
                check($sformatf("row%0d_inst", i),    inst,    word_at(vq[i].exp_pc));
            end
            @(negedge clock);
        end

        // Address wrap at the top of the 64-word instruction memory
        apply(1'b0, 1'b0, 1'b1, 32'h0000_00FC);
        check("wrap_redirect_valid", {31'd0, inst_valid}, 32'd0);
        @(negedge clock);
        apply(1'b1, 1'b0, 1'b0, 32'h0);
        check("wrap_en_top",   {31'd0, imem_en},   32'd1);
        check("wrap_addr_top", {26'd0, imem_addr}, 32'd63);
        @(negedge clock);
        apply(1'b1, 1'b0, 1'b0, 32'h0);
        check("wrap_pc_top",   inst_pc,            32'h0000_00FC);
        check("wrap_inst_top", inst,               32'h3820_0040);
        check("wrap_addr_0",   {26'd0, imem_addr}, 32'd0);
        @(negedge clock);
        apply(1'b1, 1'b0, 1'b0, 32'h0);
        check("wrap_pc_next",   inst_pc, 32'h0000_0100);
        check("wrap_inst_next", inst,    32'h3820_0001);

        // Asynchronous reset while a word is being presented
        #2;
        reset_n = 1'b0;
        #1;
        check("areset_inst_valid", {31'd0, inst_valid}, 32'd0);
        check("areset_inst_pc",    inst_pc,             32'd0);
        check("areset_imem_en",    {31'd0, imem_en},    32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        apply(1'b1, 1'b0, 1'b0, 32'h0);
        check("restart_imem_en",   {31'd0, imem_en},   32'd1);
        check("restart_imem_addr", {26'd0, imem_addr}, 32'd0);
        @(negedge clock);
        apply(1'b1, 1'b0, 1'b0, 32'h0);
        check("restart_inst_valid", {31'd0, inst_valid}, 32'd1);
        check("restart_inst_pc",    inst_pc,             32'd0);

        // Random traffic against an in-order program-stream model
        exp_pc     = 32'h0;
        prev_hold  = 1'b0;
        prev_redir = 1'b0;
        r_halt     = 1'b0;
        n_tx       = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clock);
            r_redir = (i == 0) || ($urandom_range(0, 15) == 0);
            r_pc    = $urandom;
            if ($urandom_range(0, 19) == 0) r_halt = !r_halt;
            apply(r_redir ? 1'b0 : ($urandom_range(0, 3) != 0), r_halt, r_redir, r_pc);
            if (!r_redir && prev_redir)
                check("rnd_post_redirect_valid", {31'd0, inst_valid}, 32'd0);
            if (!r_redir && prev_hold) begin
                check("rnd_hold_valid", {31'd0, inst_valid}, 32'd1);
                check("rnd_hold_pc",    inst_pc,             hold_pc);
                check("rnd_hold_inst",  inst,                hold_inst);
            end
            if (r_halt)
                check("rnd_halt_no_issue", {31'd0, imem_en}, 32'd0);
            if (inst_valid && inst_ready) begin
                check("rnd_inst_pc", inst_pc, exp_pc);
                check("rnd_inst",    inst,    word_at(exp_pc));
                exp_pc = exp_pc + 32'd4;
                n_tx++;
            end
            if (r_redir) exp_pc = r_pc & 32'hFFFF_FFFC;
            prev_hold  = inst_valid && !inst_ready && !r_redir;
            hold_pc    = inst_pc;
            hold_inst  = inst;
            prev_redir = r_redir;
        end
        check("rnd_enough_transfers", {31'd0, (n_tx >= 200)}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
